// File: rtl/prog_loader.sv
// Program loader for the accumulator CPU. It clears the 16x8 memory, fills it
// from a framed byte stream, checks the checksum, then serves as the CPU memory.
module prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              cpu_run_o,
    output logic              load_err_o,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic              cpu_we_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, CLEAR, HDR, DATA, CSUM, RUN, ERR} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    // ptr and N are one bit wider than an address so that N = DEPTH fits
    logic [ADDR_W:0]   ptr_q, ptr_d, n_q, n_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              hdr_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign in_ready_o  = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
    assign cpu_run_o   = (state_q == RUN);
    assign load_err_o  = (state_q == ERR);
    assign cpu_rdata_o = rdata_q;

    assign accept = in_valid_i && in_ready_o;
    assign hdr_ok = (in_data_i != '0) && (in_data_i <= DATA_W'(DEPTH));

    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        ptr_d     = ptr_q;
        n_d       = n_q;
        sum_d     = sum_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE, RUN, ERR: begin
                if (start_i) begin
                    state_d = CLEAR;
                    clr_d   = '0;
                end else if (state_q == RUN && cpu_we_i) begin
                    mem_we    = 1'b1;
                    mem_waddr = cpu_addr_i;
                    mem_wdata = cpu_wdata_i;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_q;
                clr_d     = clr_q + 1'b1;
                if (clr_q == ADDR_W'(DEPTH - 1)) state_d = HDR;
            end
            HDR: begin
                if (accept) begin
                    if (hdr_ok) begin
                        n_d     = in_data_i[ADDR_W:0];
                        ptr_d   = '0;
                        sum_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q[ADDR_W-1:0];
                    mem_wdata = in_data_i;
                    sum_d     = sum_q + in_data_i;
                    ptr_d     = ptr_q + 1'b1;
                    if (ptr_q + 1'b1 == n_q) state_d = CSUM;
                end
            end
            CSUM: begin
                if (accept) state_d = (in_data_i == sum_q) ? RUN : ERR;
            end
            default: state_d = IDLE;
        endcase
        // Read-first port; zero whenever RUN is not (or no longer) in force
        rdata_d = (state_q == RUN && !start_i) ? mem_q[cpu_addr_i] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            clr_q   <= '0;
            ptr_q   <= '0;
            n_q     <= '0;
            sum_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            ptr_q   <= ptr_d;
            n_q     <= n_d;
            sum_q   <= sum_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory has no reset; CLEAR is its only initialiser
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem_q[mem_waddr] <= mem_wdata;
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a table of frames plus hand sequences for
// stalls, CPU read/write ordering and reset during a load.
module tb_prog_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       start, in_valid, in_ready, cpu_run, load_err, cpu_we;
    logic [7:0] in_data, cpu_wdata, cpu_rdata;
    logic [3:0] cpu_addr;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0]       hdr;
        int               ndata;
        logic [15:0][7:0] data;
        bit               send_csum;
        logic [7:0]       csum;
        bit               exp_run;
        bit               exp_err;
        logic [3:0]       rd_addr;
        logic [7:0]       exp_rd;
    } frame_t;

    frame_t vec [6];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_ready_o (in_ready),
        .cpu_run_o  (cpu_run),
        .load_err_o (load_err),
        .cpu_addr_i (cpu_addr),
        .cpu_we_i   (cpu_we),
        .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (gap) @(negedge clk);
    endtask

    // Pulse start, check the 16-cycle clear window, then the HDR entry
    task automatic start_and_clear();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_run_drop", cpu_run, 0);
        chk("start_err_drop", load_err, 0);
        chk("clear_ready", in_ready, 0);
        chk("clear_rdata", cpu_rdata, 0);
        repeat (15) @(negedge clk);
        chk("clear_last_ready", in_ready, 0);
        @(negedge clk);
        chk("hdr_ready", in_ready, 1);
    endtask

    task automatic run_frame(input frame_t f, input bit gap);
        start_and_clear();
        send(f.hdr, gap);
        for (int i = 0; i < f.ndata; i++) send(f.data[i], gap);
        if (f.send_csum) send(f.csum, gap);
        chk("end_run", cpu_run, f.exp_run);
        chk("end_err", load_err, f.exp_err);
        chk("end_ready", in_ready, 0);
        cpu_addr = f.rd_addr;
        @(negedge clk);
        chk("end_rdata", cpu_rdata, f.exp_rd);
    endtask

    initial begin
        frame_t f;
        rst = 1'b1; start = 0; in_valid = 0; in_data = 0;
        cpu_addr = 0; cpu_we = 0; cpu_wdata = 0;

        vec[0] = '{hdr:8'd3, ndata:3, data:'0, send_csum:1, csum:8'h48,
                   exp_run:1, exp_err:0, rd_addr:4'd1, exp_rd:8'h18};
        vec[0].data[0] = 8'h08; vec[0].data[1] = 8'h18; vec[0].data[2] = 8'h28;
        vec[1] = vec[0];
        vec[1].csum = 8'h47; vec[1].exp_run = 0; vec[1].exp_err = 1; vec[1].exp_rd = 8'h00;
        vec[2] = '{hdr:8'h00, ndata:0, data:'0, send_csum:0, csum:8'h00,
                   exp_run:0, exp_err:1, rd_addr:4'd0, exp_rd:8'h00};
        vec[3] = vec[2];
        vec[3].hdr = 8'h11;
        vec[4] = '{hdr:8'd1, ndata:1, data:'0, send_csum:1, csum:8'hFF,
                   exp_run:1, exp_err:0, rd_addr:4'd0, exp_rd:8'hFF};
        vec[4].data[0] = 8'hFF;
        vec[5] = '{hdr:8'd16, ndata:16, data:'0, send_csum:1, csum:8'h00,
                   exp_run:1, exp_err:0, rd_addr:4'd15, exp_rd:8'h20};
        for (int i = 0; i < 16; i++) vec[5].data[i] = 8'h20;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_run", cpu_run, 0);
        chk("rst_err", load_err, 0);
        chk("rst_rdata", cpu_rdata, 0);

        for (int v = 0; v < 6; v++) run_frame(vec[v], 1'b0);

        // N=16 frame with wrapping checksum: every address holds 0x20
        for (int a = 0; a < 16; a++) begin
            cpu_addr = 4'(a);
            @(negedge clk);
            chk("full_read", cpu_rdata, 8'h20);
        end

        // Illegal header then a stray byte: stays in ERR, nothing accepted
        run_frame(vec[3], 1'b0);
        send(8'h02, 1'b0);
        chk("err_stray_ready", in_ready, 0);
        chk("err_stray_err", load_err, 1);

        // Stalled input, then CPU read-first write
        f = '{hdr:8'd2, ndata:2, data:'0, send_csum:1, csum:8'h33,
              exp_run:1, exp_err:0, rd_addr:4'd0, exp_rd:8'h11};
        f.data[0] = 8'h11; f.data[1] = 8'h22;
        run_frame(f, 1'b1);
        cpu_addr = 4'd1; @(negedge clk); chk("stall_a1", cpu_rdata, 8'h22);
        cpu_addr = 4'd2; @(negedge clk); chk("stall_a2", cpu_rdata, 8'h00);
        cpu_addr = 4'd3; cpu_we = 1'b1; cpu_wdata = 8'h5A;
        @(negedge clk);
        cpu_we = 1'b0;
        chk("rw_old", cpu_rdata, 8'h00);
        @(negedge clk);
        chk("rw_new", cpu_rdata, 8'h5A);

        // Reset after 2 of 4 data bytes
        start_and_clear();
        send(8'd4, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_run", cpu_run, 0);
        chk("mid_rst_err", load_err, 0);
        chk("mid_rst_rdata", cpu_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle_ready", in_ready, 0);
        f = '{hdr:8'd1, ndata:1, data:'0, send_csum:1, csum:8'h07,
              exp_run:1, exp_err:0, rd_addr:4'd0, exp_rd:8'h07};
        f.data[0] = 8'h07;
        run_frame(f, 1'b0);
        cpu_addr = 4'd1; @(negedge clk); chk("reclear_a1", cpu_rdata, 8'h00);
        cpu_addr = 4'd3; @(negedge clk); chk("reclear_a3", cpu_rdata, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
